// File: rtl/seq_checker_pkg.sv
// Shared types and default sizing for the counter-sequence checker.
package seq_checker_pkg;

    localparam int W_DEF      = 3;
    localparam int LOCK_N_DEF = 2;
    localparam int ERR_W_DEF  = 8;
    localparam int DIV_W      = 28;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

endpackage

// File: rtl/seq_checker_tick_gen.sv
// Free-running divider that emits a one-cycle pulse on each rising edge of
// divider bit DIV_BIT; only used when SEQ_CHECKER_TICKGEN_EN is defined.
module tick_gen
    import seq_checker_pkg::*;
#(
    parameter int DIV_BIT = 24
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [DIV_W-1:0] div;
    logic             div_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div   <= '0;
            div_q <= 1'b0;
        end else begin
            div   <= div + 1'b1;
            div_q <= div[DIV_BIT];
        end
    end

    assign tick = div[DIV_BIT] & ~div_q;

endmodule

// File: rtl/seq_checker.sv
// Locks onto the wrapping 0..2^W-1 counter sequence and flags out-of-sequence
// samples. Define SEQ_CHECKER_TICKGEN_EN to replace the tick port with an
// internal divider.
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int LOCK_N = LOCK_N_DEF,
    parameter int ERR_W  = ERR_W_DEF
`ifdef SEQ_CHECKER_TICKGEN_EN
    ,
    parameter int DIV_BIT = 24
`endif
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SEQ_CHECKER_TICKGEN_EN
`else
    input  logic             tick,
`endif
    input  logic             en,
    input  logic [W-1:0]     num,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [W-1:0]     last_num,
    output state_t           dbg_state
);

    localparam int GW = $clog2(LOCK_N + 1);

`ifdef SEQ_CHECKER_TICKGEN_EN
    logic tick;

    tick_gen #(.DIV_BIT(DIV_BIT)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );
`endif

    // tick is a strobe with no back-pressure: every cycle it is high (and rst
    // is low) is one independent sample of num/en; otherwise all state holds.
    state_t           state, state_n;
    logic [GW-1:0]    good, good_n;
    logic [W-1:0]     last_n;
    logic             en_s, en_s_n;
    logic             err_n;
    logic [ERR_W-1:0] cnt_n;
    logic [W-1:0]     exp_num;
    logic             match;

    assign exp_num   = en_s ? last_num + 1'b1 : last_num;
    assign match     = (num == exp_num);
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        good_n  = good;
        last_n  = last_num;
        en_s_n  = en_s;
        err_n   = 1'b0;
        cnt_n   = err_cnt;
        if (tick) begin
            last_n = num;
            en_s_n = en;
            case (state)
                HUNT: begin
                    good_n  = GW'(1);
                    state_n = (LOCK_N == 1) ? LOCK : SYNC;
                end
                SYNC: begin
                    if (!match) begin
                        good_n = GW'(1);
                    end else if (good >= GW'(LOCK_N - 1)) begin
                        good_n  = GW'(LOCK_N);
                        state_n = LOCK;
                    end else begin
                        good_n = good + 1'b1;
                    end
                end
                LOCK: begin
                    if (!match) begin
                        // Pulse on every mismatch even once the count is pinned.
                        err_n   = 1'b1;
                        if (err_cnt != '1) cnt_n = err_cnt + 1'b1;
                        good_n  = GW'(1);
                        state_n = SYNC;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            good     <= '0;
            last_num <= '0;
            en_s     <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_n;
            good     <= good_n;
            last_num <= last_n;
            en_s     <= en_s_n;
            err      <= err_n;
            err_cnt  <= cnt_n;
            locked   <= (state_n == LOCK);
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// Directed and randomized checks of seq_checker against a sample-level model
// of the lock/error rules.
module tb_seq_checker;
    import seq_checker_pkg::*;

    localparam int W      = 3;
    localparam int LOCK_N = 2;
    localparam int ERR_W  = 8;
    localparam int MOD    = 1 << W;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             en = 1'b0;
    logic [W-1:0]     num = '0;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [W-1:0]     last_num;
    state_t           dbg_state;

    seq_checker #(.W(W), .LOCK_N(LOCK_N), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .en        (en),
        .num       (num),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt),
        .last_num  (last_num),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model: per-sample view of the stream
    bit  m_have;
    int  m_last;
    bit  m_en;
    int  m_run;
    bit  m_locked;
    bit  m_err;
    int  m_errs;

    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_last = 0; m_en = 0; m_run = 0;
        m_locked = 0; m_err = 0; m_errs = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input int n, input bit e);
        int expect_n;
        m_err = 0;
        if (!m_have) begin
            m_have   = 1;
            m_run    = 1;
            m_locked = (LOCK_N == 1);
        end else begin
            expect_n = m_en ? (m_last + 1) % MOD : m_last;
            if (n == expect_n) begin
                m_run++;
                if (m_run >= LOCK_N) m_locked = 1;
            end else begin
                if (m_locked) begin
                    m_err = 1;
                    m_errs++;
                end
                m_locked = 0;
                m_run    = 1;
            end
        end
        m_last = n;
        m_en   = e;
        exp_q.push_back(W'(n));
    endtask

    task automatic check_outputs(input string tag);
        logic [W-1:0] exp_last;
        exp_last = exp_q.pop_front();
        chk({tag, ".err"}, int'(err), int'(m_err));
        chk({tag, ".locked"}, int'(locked), int'(m_locked));
        chk({tag, ".err_cnt"}, int'(err_cnt), (m_errs > ERR_MAX) ? ERR_MAX : m_errs);
        chk({tag, ".last_num"}, int'(last_num), int'(exp_last));
    endtask

    // driver: one sample, optionally followed by an idle cycle
    task automatic do_sample(input string tag, input int n, input bit e, input bit idle);
        tick = 1'b1;
        num  = W'(n);
        en   = e;
        @(posedge clk);
        #1;
        tick = 1'b0;
        model_step(n, e);
        check_outputs(tag);
        if (idle) begin
            @(posedge clk);
            #1;
            chk({tag, ".err_idle"}, int'(err), 0);
            chk({tag, ".locked_idle"}, int'(locked), int'(m_locked));
        end
    endtask

    initial begin
        int n;
        bit e;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.locked", int'(locked), 0);
        chk("reset.err", int'(err), 0);
        chk("reset.err_cnt", int'(err_cnt), 0);
        chk("reset.last_num", int'(last_num), 0);
        chk("reset.state", int'(dbg_state), int'(HUNT));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // acquire lock on 0,1,2,3
        do_sample("acq0", 0, 1'b1, 1'b1);
        chk("acq0.not_locked", int'(locked), 0);
        do_sample("acq1", 1, 1'b1, 1'b1);
        chk("acq1.locked", int'(locked), 1);
        do_sample("acq2", 2, 1'b1, 1'b0);
        do_sample("acq3", 3, 1'b1, 1'b1);

        // wrap 7 -> 0
        for (int i = 4; i < 8; i++) do_sample("wrap", i, 1'b1, 1'b0);
        do_sample("wrap0", 0, 1'b1, 1'b1);
        chk("wrap0.locked", int'(locked), 1);

        // skip 3 -> 5, then relock on 6
        for (int i = 1; i < 4; i++) do_sample("pre_skip", i, 1'b1, 1'b0);
        do_sample("skip5", 5, 1'b1, 1'b1);
        chk("skip5.err_cnt", int'(err_cnt), 1);
        do_sample("relock6", 6, 1'b1, 1'b0);
        chk("relock6.locked", int'(locked), 1);
        do_sample("relock7", 7, 1'b1, 1'b0);

        // hold with en low, then an illegal increment
        for (int i = 0; i < 4; i++) do_sample("run", i, 1'b1, 1'b0);
        do_sample("hold4a", 4, 1'b0, 1'b0);
        do_sample("hold4b", 4, 1'b0, 1'b0);
        do_sample("hold4c", 4, 1'b0, 1'b1);
        chk("hold.err_cnt", int'(err_cnt), 1);
        do_sample("hold_inc5", 5, 1'b0, 1'b1);
        chk("hold_inc5.err_cnt", int'(err_cnt), 2);

        // randomized stream: mostly legal steps, random enable and gaps
        for (int i = 0; i < 300; i++) begin
            e = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 8) n = m_en ? (m_last + 1) % MOD : m_last;
            else n = $urandom_range(0, MOD - 1);
            do_sample("rand", n, e, 1'($urandom_range(0, 1)));
        end

        // saturate the error counter: relock with one good sample, then miss
        do_sample("sat_pre", (m_last + 1) % MOD, 1'b1, 1'b0);
        do_sample("sat_pre", (m_last + 1) % MOD, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            do_sample("sat_miss", (m_last + 3) % MOD, 1'b1, 1'b0);
            do_sample("sat_good", (m_last + 1) % MOD, 1'b1, 1'b0);
        end
        do_sample("sat_last", (m_last + 3) % MOD, 1'b1, 1'b0);
        chk("sat.err_pulse", int'(err), 1);
        chk("sat.err_cnt", int'(err_cnt), ERR_MAX);

        // reset coincident with a sample while locked
        do_sample("rl0", 2, 1'b1, 1'b0);
        do_sample("rl1", 3, 1'b1, 1'b0);
        chk("rl1.locked", int'(locked), 1);
        rst  = 1'b1;
        tick = 1'b1;
        num  = W'(4);
        en   = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        tick = 1'b0;
        model_reset();
        chk("rst_tick.locked", int'(locked), 0);
        chk("rst_tick.err_cnt", int'(err_cnt), 0);
        chk("rst_tick.last_num", int'(last_num), 0);
        chk("rst_tick.state", int'(dbg_state), int'(HUNT));
        do_sample("post_rst0", 6, 1'b1, 1'b0);
        do_sample("post_rst1", 7, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
# seq_checker

Monitor for the 3-bit state-machine counter output. Samples the counter value on a sample strobe, locks onto the 0→1→…→7→0 sequence (honouring the counter's enable/hold), and flags any out-of-sequence value with an error pulse and a saturating error count. Sits on the consumer side of the counter's `num`/`en` interface, for on-board self-check and for benches.

## Interface

Parameters:
- `W`, 3, counter width; sequence wraps modulo 2^W
- `LOCK_N`, 2, consecutive in-sequence samples required to declare lock (≥1)
- `ERR_W`, 8, width of error counter
- `DIV_BIT`, 24, divider bit used for the internal tick (only with `SEQ_CHECKER_TICKGEN_EN`)

Ports:
- `clk`  in  1  single system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `tick`  in  1  sample strobe, one `clk` cycle wide (absent when `SEQ_CHECKER_TICKGEN_EN` is defined)
- `en`  in  1  counter enable as driven to the counter; sampled with `num`
- `num`  in  W  counter value under check
- `locked`  out  1  high while tracking an in-sequence stream
- `err`  out  1  one-cycle pulse per out-of-sequence sample while locked
- `err_cnt`  out  ERR_W  saturating count of `err` pulses
- `last_num`  out  W  most recently sampled `num`

## Operation

- Sample event = `tick` high on a `clk` edge with `rst` low. Between sample events, all state holds.
- Expected value: `exp = en_s ? last_num + 1 (mod 2^W) : last_num`, where `en_s` is `en` captured at the previous sample.
- FSM states: HUNT, SYNC, LOCK.
  - HUNT: on sample, capture `num`/`en` → SYNC, `good` = 1. If `LOCK_N` == 1, go directly to LOCK.
  - SYNC: on sample, if `num == exp` then `good++`; when `good` reaches `LOCK_N` → LOCK. On mismatch: recapture, `good` = 1, stay in SYNC. No `err` in SYNC.
  - LOCK: on sample, if `num == exp`, stay. On mismatch: `err` pulse, `err_cnt++` (saturates at all-ones, pulse still issued), recapture sample, → SYNC with `good` = 1.
- `last_num` and `en_s` update on every sample event in every state.
- `locked` = (state == LOCK), registered.
- Wrap: 7 → 0 is in sequence. With `en_s` low, a repeated value is in sequence and an increment is an error.

## Timing

- Reset values: state HUNT, `locked` 0, `err` 0, `err_cnt` 0, `last_num` 0, `good` 0, `en_s` 0.
- `rst` has priority over `tick`. A sample in the reset cycle is discarded. Reset mid-LOCK drops `locked` on the next edge.
- `err` rises in the cycle after the mismatching sample edge and lasts exactly one cycle. `err_cnt` updates on the same edge.
- `locked` rises on the edge that registers the `LOCK_N`-th consecutive good sample. It falls on the edge that registers a mismatch, coincident with `err`.
- Back-to-back `tick` (every cycle) is legal. Each one is an independent sample.
- Latency from the first sample after reset to `locked` = `LOCK_N` sample events.

## Configuration

- `SEQ_CHECKER_TICKGEN_EN` defined: the `tick` port is removed. An internal free-running 28-bit divider (cleared by `rst`) generates `tick` as a one-cycle pulse on each rising transition of bit `DIV_BIT`. This matches the counter's own clock division, so the checker samples once per counter step.
- Undefined: `tick` is an input port and there is no divider.

## Structure

- Package `seq_checker_pkg`: state enum (HUNT, SYNC, LOCK), default `W`, `LOCK_N`, `ERR_W`.
- Sub-module `tick_gen`: divider plus rising-edge detect, instantiated only under `SEQ_CHECKER_TICKGEN_EN`.
- `good` counter width = clog2(`LOCK_N`+1).

## Test plan

- Reset, then samples 0,1,2,3 with `en`=1, `LOCK_N`=2 → `locked` rises after sample of 1; `err` never pulses; `err_cnt`=0.
- Locked on 5,6,7 then sample 0 → wrap accepted; `locked` stays 1.
- Locked at 3, sample 5 → `err` single-cycle pulse, `err_cnt`=1, `locked`=0. Samples 6,7 → re-lock after 6.
- `en`=0 held across samples 4,4,4 → no error. Sample 5 with `en_s`=0 → `err` pulse.
- Force 300 mismatches with `ERR_W`=8 → `err_cnt` stops at 255; `err` still pulses each time.
- `rst` asserted in the same cycle as `tick` while locked → next cycle: `locked`=0, `err_cnt`=0, `last_num`=0, sample ignored.
